// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Steps the note memory address through the stored notes at a fixed tempo.
//   Each note is a LOAD phase (memory read settles, tone muted), a PLAY phase
//   (tone sounds) and an optional muted GAP phase. All outputs are registered.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        start-playback request (ignored while busy or num_notes==0)
//   stop         abort request; wins over start
//   loop         wrap to note 0 after the last note (sampled at end of note)
//   num_notes    number of stored notes, clamped to 16
//   ld_play      high while playing; selects playback addressing
//   note_counter memory address of the current note
//   next_note_en one-cycle pulse whenever note_counter is (re)loaded
//   mute         high when no tone may sound
//   busy         high in any state other than IDLE
//   done         one-cycle pulse on normal completion
module playback_sequencer #(
   parameter int unsigned NOTE_TICKS = 12_500_000,
   parameter int unsigned GAP_TICKS  = 1_250_000,
   parameter int unsigned LOAD_TICKS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   input  logic [4:0] num_notes,
   output logic       ld_play,
   output logic [3:0] note_counter,
   output logic       next_note_en,
   output logic       mute,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

   localparam logic [31:0] LOAD_LAST = 32'(LOAD_TICKS - 1);
   localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
   // GAP_LAST is only meaningful when a gap exists; guard the underflow.
   localparam logic [31:0] GAP_LAST  = 32'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
   localparam bit          HAS_GAP   = (GAP_TICKS != 0);

   state_t      state, state_d;
   logic [31:0] tick;
   logic [4:0]  len, len_d;
   logic [3:0]  cnt_d;
   logic        nne_d, done_d, eon;

   always_comb begin
      state_d = state;
      cnt_d   = note_counter;
      len_d   = len;
      nne_d   = 1'b0;
      done_d  = 1'b0;
      eon     = 1'b0;
      case (state)
         IDLE: if (start && !stop && num_notes != 5'd0) begin
            state_d = LOAD;
            cnt_d   = 4'd0;
            nne_d   = 1'b1;
            len_d   = (num_notes > 5'd16) ? 5'd16 : num_notes;
         end
         LOAD: if (tick == LOAD_LAST) state_d = PLAY;
         PLAY: if (tick == NOTE_LAST) begin
            if (HAS_GAP) state_d = GAP;
            else         eon     = 1'b1;
         end
         GAP:  if (tick == GAP_LAST) eon = 1'b1;
         default: state_d = IDLE;
      endcase

      // End of note: advance, wrap when looping, or finish.
      if (eon) begin
         if ({1'b0, note_counter} + 5'd1 < len) begin
            state_d = LOAD;
            cnt_d   = note_counter + 4'd1;
            nne_d   = 1'b1;
         end else if (loop) begin
            state_d = LOAD;
            cnt_d   = 4'd0;
            nne_d   = 1'b1;
         end else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end

      // Abort overrides everything; the address is left where it was.
      if (state != IDLE && stop) begin
         state_d = IDLE;
         cnt_d   = note_counter;
         nne_d   = 1'b0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         tick         <= '0;
         len          <= '0;
         note_counter <= '0;
         ld_play      <= 1'b0;
         next_note_en <= 1'b0;
         mute         <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         // Tick counts cycles spent in the current state; cleared on entry.
         tick         <= (state_d != state) ? 32'd0 : tick + 32'd1;
         len          <= len_d;
         note_counter <= cnt_d;
         ld_play      <= (state_d != IDLE);
         busy         <= (state_d != IDLE);
         mute         <= (state_d != PLAY);
         next_note_en <= nne_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer
//   Drives two sequencers (with and without a gap) from the same stimulus and
//   compares every output every cycle against a timeline model: each note is a
//   fixed-length period, and outputs are derived from the position within it.
module tb_playback_sequencer;
   localparam int NT = 4, LT = 2;

   logic       clk = 1'b0;
   logic       reset, start, stop, loop;
   logic [4:0] num_notes;
   logic       ld_play   [2];
   logic [3:0] note_cnt  [2];
   logic       nne       [2];
   logic       mute      [2];
   logic       busy      [2];
   logic       done      [2];

   int vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   playback_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(2), .LOAD_TICKS(LT)) u_gap (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .num_notes(num_notes), .ld_play(ld_play[0]), .note_counter(note_cnt[0]),
      .next_note_en(nne[0]), .mute(mute[0]), .busy(busy[0]), .done(done[0]));

   playback_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(0), .LOAD_TICKS(LT)) u_nogap (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .num_notes(num_notes), .ld_play(ld_play[1]), .note_counter(note_cnt[1]),
      .next_note_en(nne[1]), .mute(mute[1]), .busy(busy[1]), .done(done[1]));

   // Reference timeline: active flag, note index, position within the period.
   int period [2] = '{8, 6};
   bit m_act  [2];
   int m_idx  [2];
   int m_pos  [2];
   int m_len  [2];
   bit m_nne  [2];
   bit m_done [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_step();
      for (int j = 0; j < 2; j++) begin
         m_nne[j]  = 1'b0;
         m_done[j] = 1'b0;
         if (reset) begin
            m_act[j] = 1'b0; m_idx[j] = 0; m_pos[j] = 0; m_len[j] = 0;
         end else if (m_act[j]) begin
            if (stop) m_act[j] = 1'b0;
            else begin
               m_pos[j]++;
               if (m_pos[j] == period[j]) begin
                  m_pos[j] = 0;
                  if (m_idx[j] + 1 < m_len[j]) begin
                     m_idx[j]++; m_nne[j] = 1'b1;
                  end else if (loop) begin
                     m_idx[j] = 0; m_nne[j] = 1'b1;
                  end else begin
                     m_act[j] = 1'b0; m_done[j] = 1'b1;
                  end
               end
            end
         end else if (start && !stop && num_notes != 0) begin
            m_act[j] = 1'b1; m_idx[j] = 0; m_pos[j] = 0; m_nne[j] = 1'b1;
            m_len[j] = (num_notes > 16) ? 16 : int'(num_notes);
         end
      end
   endtask

   task automatic compare();
      for (int j = 0; j < 2; j++) begin
         bit sounding;
         sounding = m_act[j] && m_pos[j] >= LT && m_pos[j] < LT + NT;
         chk($sformatf("ld_play%0d", j), 32'(ld_play[j]), 32'(m_act[j]));
         chk($sformatf("busy%0d", j),    32'(busy[j]),    32'(m_act[j]));
         chk($sformatf("mute%0d", j),    32'(mute[j]),    32'(!sounding));
         chk($sformatf("note_counter%0d", j), 32'(note_cnt[j]), 32'(m_idx[j]));
         chk($sformatf("next_note_en%0d", j), 32'(nne[j]), 32'(m_nne[j]));
         chk($sformatf("done%0d", j),    32'(done[j]),    32'(m_done[j]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic kick(input int n);
      num_notes = 5'(n); start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; num_notes = 5'd0;
      for (int j = 0; j < 2; j++) begin
         m_act[j] = 0; m_idx[j] = 0; m_pos[j] = 0; m_len[j] = 0; m_nne[j] = 0; m_done[j] = 0;
      end
      @(negedge clk);
      cycle(); cycle();
      reset = 1'b0;

      // Three notes, plain completion.
      kick(3);
      repeat (30) cycle();

      // Sixteen notes looping; drop loop during note 15 of the second pass.
      loop = 1'b1;
      kick(16);
      repeat (128 + 15 * 8 + 2) cycle();
      loop = 1'b0;
      repeat (30) cycle();

      // Stop during PLAY of note 1, then start+stop together while idle.
      kick(3);
      repeat (10) cycle();
      stop = 1'b1; cycle(); stop = 1'b0;
      repeat (3) cycle();
      start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
      repeat (3) cycle();

      // Zero notes ignored; 20 clamps to 16; num_notes change mid-run ignored.
      kick(0);
      repeat (3) cycle();
      kick(20);
      repeat (20) cycle();
      num_notes = 5'd2;
      repeat (130) cycle();

      // Reset mid-GAP, then restart from address 0.
      kick(2);
      repeat (6) cycle();
      reset = 1'b1; cycle(); reset = 1'b0;
      repeat (2) cycle();
      kick(2);
      repeat (20) cycle();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom % 400) == 0;
         stop  = ($urandom % 150) == 0;
         start = ($urandom % 6) == 0;
         if (($urandom % 40) == 0) loop = 1'($urandom % 2);
         if (($urandom % 30) == 0) num_notes = 5'($urandom % 32);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Playback sequencer driving the note datapath during playback. On a start request it steps the memory address through the stored notes at a fixed tempo. It holds each note for a programmable duration and separates notes with a short muted gap. It generates the `ld_play`, `note_counter` and `next_note_en` controls consumed by the datapath, and a `mute` gate for the downstream tone output.

## Interface
Parameters:
- `NOTE_TICKS`, 12_500_000, clock cycles a note sounds (250 ms at 50 MHz); must be ≥ 1
- `GAP_TICKS`, 1_250_000, muted cycles after each note; 0 means no gap state
- `LOAD_TICKS`, 2, cycles allowed for the synchronous memory read to settle; must be ≥ 1

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset; synchronous, active-high
- `start`  in  1  start-playback request, sampled every cycle
- `stop`  in  1  abort request, sampled every cycle
- `loop`  in  1  level; when high, playback wraps to note 0 after the last note
- `num_notes`  in  5  number of stored notes (0..16); values > 16 are clamped to 16
- `ld_play`  out  1  high while playing; selects playback addressing in the datapath
- `note_counter`  out  4  memory address of the current note
- `next_note_en`  out  1  one-cycle pulse each time `note_counter` is (re)loaded
- `mute`  out  1  high when no tone may sound
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when playback completes normally

## Operation
- FSM states: IDLE, LOAD, PLAY, GAP.
- A 32-bit tick counter counts cycles within the current state; it is cleared on every state entry.
- A 5-bit register `len` holds `num_notes`, clamped to 16; it is latched only when a start is accepted.
- Outputs are registered.
- IDLE: `ld_play`=0, `mute`=1, `busy`=0.
  - `start`=1 with `num_notes` ≠ 0 and `stop`=0 → LOAD.
  - On this transition: `note_counter`←0, `next_note_en` pulses, `len` is latched.
  - `start` with `num_notes`=0 is ignored.
- LOAD: `ld_play`=1, `mute`=1. After `LOAD_TICKS` cycles → PLAY.
- PLAY: `ld_play`=1, `mute`=0. After `NOTE_TICKS` cycles → GAP, or go straight to end-of-note handling if `GAP_TICKS`=0.
- GAP: `ld_play`=1, `mute`=1. After `GAP_TICKS` cycles → end-of-note handling.
- End of note:
  - If `note_counter` < `len`−1: `note_counter`+1 → LOAD, with an `next_note_en` pulse.
  - Else if `loop`=1: `note_counter`←0 → LOAD, with an `next_note_en` pulse.
  - Else → IDLE, with a `done` pulse. `note_counter` holds its last value.
- `stop`=1 in any non-IDLE state → IDLE on the next edge.
  - Outputs take their IDLE values; `done` is not pulsed; `note_counter` holds.
- `start` while `busy` is ignored; `len` does not change mid-playback.
- `stop` and `start` in the same cycle: `stop` wins and no playback starts.
- `loop` is sampled only at end-of-note. Clearing it mid-note ends playback after the current last note.
- `reset`=1 at any time, including mid-playback, on the next edge:
  - state IDLE, `note_counter`=0, `len`=0
  - `ld_play`=0, `next_note_en`=0, `busy`=0, `done`=0, `mute`=1

## Timing
- Start latency: `start` sampled high at edge k → after k, `busy`=1, `ld_play`=1, `note_counter`=0, `next_note_en`=1 for that one cycle.
- Mute release: `mute` falls after edge k+`LOAD_TICKS`, once memory data is valid in the datapath.
- Per-note period is exactly `LOAD_TICKS`+`NOTE_TICKS`+`GAP_TICKS` cycles.
- A new `note_counter` value and its `next_note_en` pulse appear in the same cycle.
- Completion: `done` and `busy`=0 appear in the same cycle, N×period cycles after edge k for N = `len`.
- Stop latency: 1 cycle.
- Address wrap: address 15 wraps to 0 when `len`=16.
- `next_note_en` is never high in two consecutive cycles.

## Test plan
Benches use `NOTE_TICKS`=4, `GAP_TICKS`=2, `LOAD_TICKS`=2, so the note period is 8 cycles.
1. Reset, then `num_notes`=3 with a 1-cycle `start` at edge k → `note_counter` reads 0,1,2 at k+1, k+9, k+17, each with a 1-cycle `next_note_en`; `mute`=0 only in cycles k+3..k+6 of each period; `done`=1 and `busy`=0 at k+25.
2. `num_notes`=16, `loop`=1 → `note_counter` runs 15→0 with `next_note_en` and no `done`; clear `loop` during note 15 → `done` after note 15 of that pass.
3. `stop` during PLAY of note 1 → next cycle `busy`=0, `mute`=1, `ld_play`=0, `done`=0, `note_counter`=1; `start` and `stop` together in IDLE → stays IDLE.
4. `num_notes`=0 with `start` → stays IDLE; `num_notes`=20 → plays 16 notes; changing `num_notes` mid-playback has no effect.
5. `GAP_TICKS`=0 → period is 6 cycles and `mute` never rises between PLAY and the next LOAD except during LOAD.
6. `reset`=1 asserted mid-GAP for 1 cycle → all outputs at reset values next cycle; a later `start` begins again at address 0.
